// File: rtl/apb_alu_pkg.sv
// Shared definitions for the APB ALU scheduler.
// Holds the scheduler FSM state type, the ALU opcode encodings, the ALU
// device register offsets and a helper that maps a transfer step to its
// register address.
package apb_alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Opcode encodings as seen on req_op and written to the CTRL register.
    localparam logic [1:0] OP_ILLEGAL = 2'd0;
    localparam logic [1:0] OP_AND     = 2'd1;
    localparam logic [1:0] OP_OR      = 2'd2;
    localparam logic [1:0] OP_XOR     = 2'd3;

    // ALU device register map.
    localparam logic [31:0] REG_OPA  = 32'h0000_0000;
    localparam logic [31:0] REG_OPB  = 32'h0000_0004;
    localparam logic [31:0] REG_RES  = 32'h0000_0008;
    localparam logic [31:0] REG_CTRL = 32'h0000_000C;

    // Step 0 writes A, step 1 writes B, step 2 writes the opcode, step 3
    // reads the result back.
    function automatic logic [31:0] step_addr(input logic [1:0] step);
        logic [31:0] addr;
        case (step)
            2'd0:    addr = REG_OPA;
            2'd1:    addr = REG_OPB;
            2'd2:    addr = REG_CTRL;
            default: addr = REG_RES;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/apb_alu_sched_if.sv
// Bundle of the requester handshake, the response strobe and the APB bus
// toward the ALU device.
//   master : the scheduler side (drives req_ready, rsp_*, APB controls)
//   slave  : the environment side (requesters, response sink, APB device)
// Handshake: a requester raises req_valid[n] with its operands and holds
// them stable until req_ready[n] is seen high; the job transfers on the
// rising clock edge where both are high. rsp_valid is a one-cycle strobe
// with no backpressure.
interface apb_alu_sched_if;

    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_op;

    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_err;

    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        input  req_valid, req_a, req_b, req_op, PRDATA, PREADY,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_a, req_b, req_op, PRDATA, PREADY,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   i_clk, i_rst    : clock, asynchronous active-high reset
//   i_valid[1:0]    : request lines
//   i_enable        : grants may be issued this cycle
//   o_grant[1:0]    : one-hot grant (zero when disabled or no request)
//   o_grant_id      : index of the requester that would be granted
// A lone requester always wins; with both requesting, the one not granted
// last wins. The last-grant register resets to 1 so requester 0 wins the
// first contested round.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_valid,
    input  logic       i_enable,
    output logic [1:0] o_grant,
    output logic       o_grant_id
);

    logic r_last;
    logic w_pick;

    always_comb begin
        w_pick = (i_valid == 2'b11) ? ~r_last : i_valid[1];
        o_grant_id = w_pick;
        o_grant = 2'b00;
        if (i_enable && (i_valid != 2'b00)) begin
            o_grant = w_pick ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last <= 1'b1;
        end else if (o_grant != 2'b00) begin
            r_last <= w_pick;
        end
    end

endmodule

// File: rtl/apb_alu_sched.sv
// Scheduler that serves two requesters by running each job on an APB ALU
// device: write A, write B, write the opcode, read the result.
// Ports:
//   PCLK, PRESET : clock, asynchronous active-high reset
//   bus          : requester handshake, response strobe and APB master
//   o_dbg_state  : current FSM state
// Parameter TIMEOUT bounds the ACCESS cycles waited for PREADY; on expiry
// the job ends with rsp_err=1 and the remaining steps are skipped.
module apb_alu_sched
    import apb_alu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic               PCLK,
    input  logic               PRESET,
    apb_alu_sched_if.master    bus,
    output state_t             o_dbg_state
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t            r_state;
    logic [1:0]        r_step;
    logic [WAIT_W-1:0] r_wait;
    logic [31:0]       r_b;
    logic [1:0]        r_op;
    logic              r_id;

    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [31:0]       r_paddr;
    logic [31:0]       r_pwdata;

    logic              r_rsp_valid;
    logic              r_rsp_id;
    logic [31:0]       r_rsp_data;
    logic              r_rsp_err;

    logic              w_arb_en;
    logic [1:0]        w_grant;
    logic              w_gid;
    logic              w_accept;
    logic [31:0]       w_a;
    logic [31:0]       w_b;
    logic [1:0]        w_op;
    logic [1:0]        w_step_nx;
    logic [31:0]       w_wdata_nx;

    // Grants only in IDLE and never while reset is held, so req_ready has
    // no path from the APB side.
    assign w_arb_en = (r_state == ST_IDLE) && !PRESET;

    rr_arb2 u_arb (
        .i_clk      (PCLK),
        .i_rst      (PRESET),
        .i_valid    (bus.req_valid),
        .i_enable   (w_arb_en),
        .o_grant    (w_grant),
        .o_grant_id (w_gid)
    );

    assign w_accept      = (w_grant != 2'b00);
    assign bus.req_ready = w_grant;

    always_comb begin
        w_a  = w_gid ? bus.req_a[63:32] : bus.req_a[31:0];
        w_b  = w_gid ? bus.req_b[63:32] : bus.req_b[31:0];
        w_op = w_gid ? bus.req_op[3:2]  : bus.req_op[1:0];
    end

    // Write data for the step that follows the current one. Step 0 is only
    // entered from IDLE, where A is loaded straight into PWDATA, so A never
    // needs its own holding register.
    always_comb begin
        w_step_nx = r_step + 2'd1;
        case (w_step_nx)
            2'd1:    w_wdata_nx = r_b;
            2'd2:    w_wdata_nx = {30'd0, r_op};
            default: w_wdata_nx = 32'd0;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state     <= ST_IDLE;
            r_step      <= 2'd0;
            r_wait      <= '0;
            r_b         <= 32'd0;
            r_op        <= 2'd0;
            r_id        <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= 32'd0;
            r_pwdata    <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_step <= 2'd0;
                    r_wait <= '0;
                    if (w_accept) begin
                        r_b  <= w_b;
                        r_op <= w_op;
                        r_id <= w_gid;
                        if (w_op == OP_ILLEGAL) begin
                            // Illegal opcode: answer at once, bus untouched.
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_id    <= w_gid;
                            r_rsp_data  <= 32'd0;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            r_state   <= ST_SETUP;
                            r_psel    <= 1'b1;
                            r_penable <= 1'b0;
                            r_pwrite  <= 1'b1;
                            r_paddr   <= step_addr(2'd0);
                            r_pwdata  <= w_a;
                        end
                    end
                end

                ST_SETUP: begin
                    r_state   <= ST_ACCESS;
                    r_penable <= 1'b1;
                    r_wait    <= '0;
                end

                ST_ACCESS: begin
                    if (bus.PREADY) begin
                        if (r_step == 2'd3) begin
                            r_state     <= ST_RESP;
                            r_psel      <= 1'b0;
                            r_penable   <= 1'b0;
                            r_pwrite    <= 1'b0;
                            r_paddr     <= 32'd0;
                            r_pwdata    <= 32'd0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_id    <= r_id;
                            r_rsp_data  <= bus.PRDATA;
                            r_rsp_err   <= 1'b0;
                        end else begin
                            r_state   <= ST_SETUP;
                            r_step    <= w_step_nx;
                            r_penable <= 1'b0;
                            r_pwrite  <= (w_step_nx != 2'd3);
                            r_paddr   <= step_addr(w_step_nx);
                            r_pwdata  <= w_wdata_nx;
                        end
                    end else if (r_wait == WAIT_LAST) begin
                        // This is the TIMEOUT-th cycle without PREADY: abort.
                        r_state     <= ST_RESP;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_pwrite    <= 1'b0;
                        r_paddr     <= 32'd0;
                        r_pwdata    <= 32'd0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_id;
                        r_rsp_data  <= 32'd0;
                        r_rsp_err   <= 1'b1;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end

                ST_RESP: begin
                    r_state    <= ST_IDLE;
                    r_step     <= 2'd0;
                    r_rsp_id   <= 1'b0;
                    r_rsp_data <= 32'd0;
                    r_rsp_err  <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.PSEL      = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_apb_alu_sched.sv
// Bench for apb_alu_sched. Jobs are described at transaction level and
// expanded into a per-cycle table of expected outputs plus the matching
// input stimulus; a small ALU device answers the APB bus.
module tb_apb_alu_sched;
    import apb_alu_pkg::*;

    localparam int TIMEOUT = 16;

    // ---------------- clock / reset ----------------
    logic   PCLK   = 1'b0;
    logic   PRESET = 1'b1;
    state_t dbg_state;

    always #5 PCLK = ~PCLK;

    apb_alu_sched_if bus();

    apb_alu_sched #(.TIMEOUT(TIMEOUT)) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- types and queues ----------------
    typedef struct {
        logic [1:0]  valid;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  op;
        logic        pready;
        logic        rst;
    } stim_t;

    typedef struct packed {
        logic        is_rst;
        logic [1:0]  ready;
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic        rsp_valid;
        logic        rsp_id;
        logic [31:0] rsp_data;
        logic        rsp_err;
    } exp_t;

    localparam int EXP_W = $bits(exp_t);

    typedef struct {
        int          cyc;
        logic        id;
        logic [31:0] data;
        logic        err;
    } rsp_rec_t;

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    stim_t            stim_q[$];
    logic [EXP_W-1:0] exp_q[$];
    int               accept_log[$];
    rsp_rec_t         rsp_log[$];
    xfer_t            xfer_log[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int psel_cycles = 0;

    // Reference state: last grant, requester still waiting, per-lane jobs.
    int          m_last = 1;
    logic [1:0]  m_carry = 2'b00;
    logic [31:0] la[2];
    logic [31:0] lb[2];
    logic [1:0]  lop[2];

    // ---------------- reference helpers ----------------
    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] addr_of(input int s);
        case (s)
            0:       return 32'h0;
            1:       return 32'h4;
            2:       return 32'hC;
            default: return 32'h8;
        endcase
    endfunction

    function automatic stim_t make_stim(input logic [1:0] hold, input logic pr, input logic rst);
        stim_t s;
        s.valid  = hold;
        s.pready = pr;
        s.rst    = rst;
        s.a      = '0;
        s.b      = '0;
        s.op     = '0;
        for (int i = 0; i < 2; i++) begin
            if (hold[i]) begin
                s.a[32*i +: 32] = la[i];
                s.b[32*i +: 32] = lb[i];
                s.op[2*i +: 2]  = lop[i];
            end else begin
                s.a[32*i +: 32] = $urandom;
                s.b[32*i +: 32] = $urandom;
                s.op[2*i +: 2]  = 2'($urandom_range(0, 3));
            end
        end
        return s;
    endfunction

    task automatic push(input stim_t s, input exp_t e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic gen_reset();
        exp_t e;
        e = '0;
        e.is_rst = 1'b1;
        push(make_stim(2'b00, 1'b0, 1'b1), e);
        m_last  = 1;
        m_carry = 2'b00;
    endtask

    task automatic gen_idle(input int n);
        exp_t e;
        e = '0;
        for (int i = 0; i < n; i++) push(make_stim(2'b00, 1'($urandom_range(0, 1)), 1'b0), e);
    endtask

    // One job from acceptance to response. w[s] is the number of PREADY-low
    // ACCESS cycles in step s (TIMEOUT or more means the device never
    // answers); rst_step >= 0 pulses reset in that step's first ACCESS cycle.
    task automatic gen_job(input logic [1:0] mask, input int w[4], input int rst_step);
        exp_t        e;
        logic        g;
        logic [1:0]  hold;
        logic [31:0] ja, jb;
        logic [1:0]  jo;
        if (mask == 2'b11) g = (m_last == 0);
        else               g = mask[1];
        m_last = g ? 1 : 0;
        hold = mask & ~(2'b01 << g);
        ja = la[g];
        jb = lb[g];
        jo = lop[g];
        e = '0;
        e.ready = 2'b01 << g;
        push(make_stim(mask, 1'($urandom_range(0, 1)), 1'b0), e);
        m_carry = hold;
        if (jo == 2'd0) begin
            e = '0;
            e.rsp_valid = 1'b1;
            e.rsp_id    = g;
            e.rsp_err   = 1'b1;
            push(make_stim(hold, 1'($urandom_range(0, 1)), 1'b0), e);
            return;
        end
        for (int s = 0; s < 4; s++) begin
            e = '0;
            e.psel   = 1'b1;
            e.pwrite = (s < 3);
            e.paddr  = addr_of(s);
            e.pwdata = (s == 0) ? ja : (s == 1) ? jb : (s == 2) ? {30'd0, jo} : 32'd0;
            push(make_stim(hold, 1'($urandom_range(0, 1)), 1'b0), e);
            e.penable = 1'b1;
            if (rst_step == s) begin
                gen_reset();
                return;
            end
            if (w[s] >= TIMEOUT) begin
                for (int k = 0; k < TIMEOUT; k++) push(make_stim(hold, 1'b0, 1'b0), e);
                e = '0;
                e.rsp_valid = 1'b1;
                e.rsp_id    = g;
                e.rsp_err   = 1'b1;
                push(make_stim(hold, 1'($urandom_range(0, 1)), 1'b0), e);
                return;
            end
            for (int k = 0; k < w[s]; k++) push(make_stim(hold, 1'b0, 1'b0), e);
            push(make_stim(hold, 1'b1, 1'b0), e);
        end
        e = '0;
        e.rsp_valid = 1'b1;
        e.rsp_id    = g;
        e.rsp_data  = alu(ja, jb, jo);
        push(make_stim(hold, 1'($urandom_range(0, 1)), 1'b0), e);
    endtask

    // ---------------- ALU device ----------------
    logic [31:0] dev_a, dev_b;
    logic [1:0]  dev_op;

    always @(posedge PCLK) begin
        if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE) begin
            case (bus.PADDR)
                32'h0:   dev_a  <= bus.PWDATA;
                32'h4:   dev_b  <= bus.PWDATA;
                32'hC:   dev_op <= bus.PWDATA[1:0];
                default: ;
            endcase
        end
    end

    always_comb bus.PRDATA = alu(dev_a, dev_b, dev_op);

    // ---------------- driver ----------------
    always @(negedge PCLK) begin
        stim_t s;
        if (stim_q.size() > 0) s = stim_q.pop_front();
        else                   s = make_stim(2'b00, 1'b0, 1'b0);
        bus.req_valid = s.valid;
        bus.req_a     = s.a;
        bus.req_b     = s.b;
        bus.req_op    = s.op;
        bus.PREADY    = s.pready;
        PRESET        = s.rst;
        if (s.rst) begin
            #3;
            PRESET = 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, want);
        end
    endtask

    always @(negedge PCLK) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_t'(exp_q.pop_front());
            chk("req_ready", 128'(bus.req_ready), 128'(e.ready));
            chk("apb", 128'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}),
                128'({e.psel, e.penable, e.pwrite, e.paddr, e.pwdata}));
            chk("rsp_valid", 128'(bus.rsp_valid), 128'(e.rsp_valid));
            if (e.rsp_valid)
                chk("rsp", 128'({bus.rsp_id, bus.rsp_data, bus.rsp_err}),
                    128'({e.rsp_id, e.rsp_data, e.rsp_err}));
            if (e.is_rst)
                chk("rst_state", 128'(dbg_state), 128'(ST_IDLE));
        end
        if (bus.req_ready != 2'b00) accept_log.push_back(cyc);
        if (bus.rsp_valid) rsp_log.push_back('{cyc, bus.rsp_id, bus.rsp_data, bus.rsp_err});
        if (bus.PSEL) psel_cycles++;
        if (bus.PSEL && bus.PENABLE && bus.PREADY)
            xfer_log.push_back('{bus.PWRITE, bus.PADDR, bus.PWRITE ? bus.PWDATA : bus.PRDATA});
        cyc++;
    end

    task automatic run();
        int budget;
        budget = 0;
        while (exp_q.size() > 0 && budget < 20000) begin
            @(posedge PCLK);
            budget++;
        end
        chk("drain", 128'(exp_q.size()), 128'(0));
        @(posedge PCLK);
    endtask

    task automatic check_rsp(input string nm, input int ai, input int ri, input int lat,
                             input logic id, input logic [31:0] data, input logic err);
        chk({nm, "_present"}, 128'(rsp_log.size() > ri && accept_log.size() > ai), 128'(1));
        if (rsp_log.size() > ri && accept_log.size() > ai) begin
            chk({nm, "_latency"}, 128'(rsp_log[ri].cyc - accept_log[ai]), 128'(lat));
            chk({nm, "_resp"}, 128'({rsp_log[ri].id, rsp_log[ri].data, rsp_log[ri].err}),
                128'({id, data, err}));
        end
    endtask

    task automatic check_xfer(input string nm, input int xi, input logic w,
                              input logic [31:0] addr, input logic [31:0] data);
        chk({nm, "_present"}, 128'(xfer_log.size() > xi), 128'(1));
        if (xfer_log.size() > xi)
            chk(nm, 128'({xfer_log[xi].w, xfer_log[xi].addr, xfer_log[xi].data}), 128'({w, addr, data}));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int ai, ri, xi, pc;
        int w0[4];
        int wr[4];
        logic [1:0] mask;
        int rs;
        w0 = '{0, 0, 0, 0};

        gen_reset();
        gen_reset();
        run();

        // Scenario 1: single AND job, zero wait.
        ai = accept_log.size(); ri = rsp_log.size(); xi = xfer_log.size();
        la[0] = 32'd3; lb[0] = 32'd7; lop[0] = 2'd1;
        gen_job(2'b01, w0, -1);
        gen_idle(2);
        run();
        check_rsp("s1", ai, ri, 9, 1'b0, 32'd3, 1'b0);
        check_xfer("s1_x0", xi,     1'b1, 32'h0, 32'd3);
        check_xfer("s1_x1", xi + 1, 1'b1, 32'h4, 32'd7);
        check_xfer("s1_x2", xi + 2, 1'b1, 32'hC, 32'd1);
        check_xfer("s1_x3", xi + 3, 1'b0, 32'h8, 32'd3);

        // Scenario 2: both requesters valid right after reset.
        gen_reset();
        la[0] = 32'd9;   lb[0] = 32'd3; lop[0] = 2'd3;
        la[1] = 32'hA;   lb[1] = 32'd4; lop[1] = 2'd2;
        run();
        ai = accept_log.size(); ri = rsp_log.size();
        gen_job(2'b11, w0, -1);
        gen_job(m_carry, w0, -1);
        gen_idle(1);
        run();
        check_rsp("s2_r0", ai, ri,     9,  1'b0, 32'hA, 1'b0);
        check_rsp("s2_r1", ai, ri + 1, 19, 1'b1, 32'hE, 1'b0);

        // Scenario 3: PREADY low for two cycles in every ACCESS.
        ai = accept_log.size(); ri = rsp_log.size();
        la[1] = 32'h5A5A_00FF; lb[1] = 32'h0F0F_0F0F; lop[1] = 2'd2;
        gen_job(2'b10, '{2, 2, 2, 2}, -1);
        gen_idle(1);
        run();
        check_rsp("s3", ai, ri, 17, 1'b1, 32'h5F5F_0FFF, 1'b0);

        // Scenario 4: device never answers.
        ai = accept_log.size(); ri = rsp_log.size(); xi = xfer_log.size();
        la[0] = 32'h1234; lb[0] = 32'h00FF; lop[0] = 2'd1;
        gen_job(2'b01, '{TIMEOUT, 0, 0, 0}, -1);
        gen_idle(3);
        run();
        check_rsp("s4", ai, ri, TIMEOUT + 2, 1'b0, 32'd0, 1'b1);
        chk("s4_no_xfer", 128'(xfer_log.size() - xi), 128'(0));

        // Scenario 5: illegal opcode.
        ai = accept_log.size(); ri = rsp_log.size(); pc = psel_cycles;
        la[0] = 32'hFFFF; lb[0] = 32'h1; lop[0] = 2'd0;
        gen_job(2'b01, w0, -1);
        gen_idle(1);
        run();
        check_rsp("s5", ai, ri, 1, 1'b0, 32'd0, 1'b1);
        chk("s5_no_psel", 128'(psel_cycles - pc), 128'(0));

        // Scenario 6: reset during the step-2 ACCESS, then a fresh job.
        ri = rsp_log.size();
        la[0] = 32'hDEAD_BEEF; lb[0] = 32'h0000_FFFF; lop[0] = 2'd1;
        gen_job(2'b01, w0, 2);
        run();
        chk("s6_no_rsp", 128'(rsp_log.size() - ri), 128'(0));
        xi = xfer_log.size(); ai = accept_log.size(); ri = rsp_log.size();
        la[0] = 32'h0000_00F0; lb[0] = 32'h0000_0FF0; lop[0] = 2'd3;
        gen_job(2'b01, w0, -1);
        gen_idle(1);
        run();
        check_xfer("s6_first", xi, 1'b1, 32'h0, 32'h0000_00F0);
        check_rsp("s6", ai, ri, 9, 1'b0, 32'h0000_0F00, 1'b0);

        // Randomized traffic.
        for (int j = 0; j < 60; j++) begin
            mask = m_carry | 2'($urandom_range(0, 3));
            if (mask == 2'b00) mask = 2'b01;
            for (int i = 0; i < 2; i++) begin
                if (mask[i] && !m_carry[i]) begin
                    la[i]  = $urandom;
                    lb[i]  = $urandom;
                    lop[i] = ($urandom_range(0, 7) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
                end
            end
            for (int s = 0; s < 4; s++) begin
                rs = $urandom_range(0, 39);
                if (rs == 0)      wr[s] = TIMEOUT;
                else if (rs == 1) wr[s] = TIMEOUT - 1;
                else if (rs < 25) wr[s] = 0;
                else              wr[s] = $urandom_range(1, 3);
            end
            rs = ($urandom_range(0, 24) == 0) ? $urandom_range(0, 3) : -1;
            if (m_carry == 2'b00 && $urandom_range(0, 2) == 0) gen_idle($urandom_range(1, 2));
            gen_job(mask, wr, rs);
        end
        while (m_carry != 2'b00) gen_job(m_carry, w0, -1);
        gen_idle(2);
        run();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_alu_sched.md
APB_ALU_SCHED -- requirements
Module: apb_alu_sched

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum ACCESS-phase cycles waited for PREADY before a transfer is aborted.
REQ-002 PCLK  in  1  single clock; all state updates on its rising edge.
REQ-003 PRESET  in  1  reset, asynchronous, active-high.
REQ-004 req_valid  in  2  bit n = requester n holds a job.
REQ-005 req_ready  out  2  bit n = job of requester n accepted this cycle.
REQ-006 req_a  in  64  operand A; bits [32n+31:32n] belong to requester n.
REQ-007 req_b  in  64  operand B; same packing as req_a.
REQ-008 req_op  in  4  opcode, bits [2n+1:2n]; 1=AND, 2=OR, 3=XOR, 0=illegal.
REQ-009 rsp_valid  out  1  one-cycle response strobe.
REQ-010 rsp_id  out  1  requester the response belongs to.
REQ-011 rsp_data  out  32  result read from the device.
REQ-012 rsp_err  out  1  illegal opcode or timeout.
REQ-013 PSEL, PENABLE, PWRITE  out  1 each  APB controls toward the ALU device.
REQ-014 PADDR, PWDATA  out  32 each  APB address and write data.
REQ-015 PRDATA  in  32, PREADY  in  1  APB read data and ready from the device.

Function
REQ-016 FSM states are IDLE, SETUP, ACCESS, RESP; a 2-bit step counter selects the transfer.
REQ-017 Step sequence: 0 = write 0x0 with A; 1 = write 0x4 with B; 2 = write 0xC with op; 3 = read 0x8.
REQ-018 In IDLE with any req_valid, grant round-robin: the sole requester if only one is valid; if both, the one not granted last; last-grant resets to 1, so requester 0 wins first.
REQ-019 req_ready[n] is high only in IDLE for the granted n; it is combinational from req_valid and state, with no path from PREADY or PRDATA.
REQ-020 On accept, A, B, op and id are latched; later input changes are ignored until the next accept.
REQ-021 A requester holds req_valid and its data stable until req_ready; a valid that drops before grant is simply not served.
REQ-022 op=0 on accept: no APB activity; next state is RESP with rsp_err=1 and rsp_data=0.
REQ-023 SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA per step (PWDATA=0 on read); the FSM moves to ACCESS next cycle.
REQ-024 ACCESS: PSEL=1, PENABLE=1, address/data/write held from SETUP; the FSM stays while PREADY=0.
REQ-025 ACCESS with PREADY=1: if step<3, step+1 and go to SETUP; if step=3, capture PRDATA and go to RESP.
REQ-026 A wait counter clears on entering ACCESS; if it reaches TIMEOUT with PREADY=0, go to RESP with rsp_err=1 and rsp_data=0, and skip the remaining steps.
REQ-027 RESP: rsp_valid=1 for exactly one cycle with no backpressure; rsp_id and rsp_data are valid in that cycle; the next state is IDLE.
REQ-028 Zero-wait latency: accept at cycle T gives rsp_valid at T+9; the next accept is possible at T+10.
REQ-029 Outside SETUP/ACCESS: PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0; outside RESP: rsp_valid=0.
REQ-030 PREADY is ignored outside ACCESS.

Reset
REQ-031 PRESET asynchronously forces IDLE, step=0, wait counter=0, last-grant=1, and every output to 0 (req_ready follows once PRESET is released).
REQ-032 Reset mid-job: PSEL/PENABLE drop immediately, the job is discarded, and no response is issued.

Structure
REQ-033 Package apb_alu_pkg holds: state enum; opcode constants (AND=1, OR=2, XOR=3); register offsets OPA=0x0, OPB=0x4, RES=0x8, CTRL=0xC.
REQ-034 Sub-module rr_arb2 implements the 2-way round-robin grant and last-grant register; all other logic sits in apb_alu_sched.

Verification
REQ-035 Scenario 1: req0 a=3, b=7, op=1, PREADY=1, device returns 3 -> APB sequence W0x0=3, W0x4=7, W0xC=1, R0x8; rsp at T+9 with id=0, data=3, err=0.
REQ-036 Scenario 2: both requesters valid after reset; req0 a=9, b=3, op=3; req1 a=0xA, b=4, op=2 -> req0 served first (data 0xA, at T+9), then req1 (data 0xE, id=1, at T+19).
REQ-037 Scenario 3: PREADY low for 2 cycles in every ACCESS -> each ACCESS lasts 3 cycles; rsp at T+17 with correct data.
REQ-038 Scenario 4: TIMEOUT=16, PREADY stuck at 0 -> abort after 16 ACCESS cycles; rsp err=1, data=0; PSEL=0 afterwards; no further steps.
REQ-039 Scenario 5: op=0 -> PSEL never asserted; rsp at T+1 with err=1.
REQ-040 Scenario 6: PRESET pulsed during step 2 ACCESS -> PSEL/PENABLE fall in the same cycle; no rsp; the next job starts at step 0 with write 0x0.
